cpu_controller: RTL

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller_if.sv | 34 +++
 rtl/cpu_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath/debug signal bundle for cpu_controller.
// master = controller side, slave = datapath/key-filter side.
interface cpu_controller_if #(
  parameter int PC_W = 8
);
  logic            Step;
  logic [15:0]     IR_In;
  logic [PC_W-1:0] PC_Out;
  logic            IM_Rd;
  logic            IR_Ld;
  logic [PC_W-1:0] D_Addr;
  logic            D_Wr;
  logic            RF_s;
  logic [3:0]      RF_W_Addr;
  logic            RF_W_En;
  logic [3:0]      RF_Ra_Addr;
  logic [3:0]      RF_Rb_Addr;
  logic [2:0]      ALU_s0;
  logic [7:0]      StateOut;
  logic [7:0]      NextStateOut;
  logic            Halted;

  modport master (
    input  Step, IR_In,
    output PC_Out, IM_Rd, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, StateOut, NextStateOut, Halted
  );

  modport slave (
    output Step, IR_In,
    input  PC_Out, IM_Rd, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
           RF_Ra_Addr, RF_Rb_Addr, ALU_s0, StateOut, NextStateOut, Halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle control unit: fetch/decode/execute FSM plus program counter.
// Define CPU_CTRL_STEP_MODE_EN to advance only on Step strobes (single-step debug).
module cpu_controller #(
  parameter int PC_W = 8
) (
  input logic            Clock,
  input logic            Reset,
  cpu_controller_if.master bus
);

  typedef enum logic [7:0] {
    S_INIT   = 8'h00,
    S_FETCH  = 8'h01,
    S_DECODE = 8'h02,
    S_NOOP   = 8'h03,
    S_LOADA  = 8'h04,
    S_LOADB  = 8'h05,
    S_STORE  = 8'h06,
    S_ADD    = 8'h07,
    S_SUB    = 8'h08,
    S_HALT   = 8'h09
  } state_t;

  state_t          state, next_state;
  logic [PC_W-1:0] pc;
  logic            advance;

  logic            im_rd, ir_ld, d_wr, rf_s, rf_w_en, halted;
  logic [PC_W-1:0] d_addr;
  logic [3:0]      rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]      alu_s0;

`ifdef CPU_CTRL_STEP_MODE_EN
  assign advance = bus.Step;
`else
  logic step_unused;
  assign step_unused = bus.Step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
      pc    <= '0;
    end else if (advance) begin
      state <= next_state;
      if (state == S_FETCH) pc <= pc + PC_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (bus.IR_In[15:12])
          4'd1:    next_state = S_STORE;
          4'd2:    next_state = S_LOADA;
          4'd3:    next_state = S_ADD;
          4'd4:    next_state = S_SUB;
          4'd5:    next_state = S_HALT;
          default: next_state = S_NOOP;
        endcase
      end
      S_LOADA:  next_state = S_LOADB;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    im_rd      = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s0     = '0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        im_rd = 1'b1;
        ir_ld = 1'b1;
      end
      S_LOADA, S_LOADB: begin
        d_addr    = PC_W'(bus.IR_In[11:4]);
        rf_s      = 1'b1;
        rf_w_addr = bus.IR_In[3:0];
        rf_w_en   = (state == S_LOADB);
      end
      S_STORE: begin
        d_addr     = PC_W'(bus.IR_In[11:4]);
        rf_ra_addr = bus.IR_In[3:0];
        d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = bus.IR_In[11:8];
        rf_rb_addr = bus.IR_In[7:4];
        rf_w_addr  = bus.IR_In[3:0];
        rf_w_en    = 1'b1;
        alu_s0     = (state == S_ADD) ? 3'd1 : 3'd2;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are gated by the advance qualifier so each fires once per step.
  assign bus.IM_Rd        = im_rd;
  assign bus.IR_Ld        = ir_ld & advance;
  assign bus.D_Wr         = d_wr & advance;
  assign bus.RF_W_En      = rf_w_en & advance;
  assign bus.D_Addr       = d_addr;
  assign bus.RF_s         = rf_s;
  assign bus.RF_W_Addr    = rf_w_addr;
  assign bus.RF_Ra_Addr   = rf_ra_addr;
  assign bus.RF_Rb_Addr   = rf_rb_addr;
  assign bus.ALU_s0       = alu_s0;
  assign bus.Halted       = halted;
  assign bus.PC_Out       = pc;
  assign bus.StateOut     = state;
  assign bus.NextStateOut = next_state;

endmodule
